// File: rtl/fx_arb.sv
// fx_arb: two-master round-robin arbiter issuing one single-beat fx bus write or read per grant
module fx_arb #(
  parameter int AW     = 22,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          fx_wr,
  output logic [AW-1:0] fx_waddr,
  output logic [DW-1:0] fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [DW-1:0] fx_q,
  output logic [1:0]    gnt,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  localparam logic [2:0] LAT = 3'(RD_LAT);
  state_t        state_q;
  logic          ptr_q, win_q, wr_q, rd_q, busy_q;
  logic [1:0]    gnt_q, ack_q;
  logic [2:0]    cnt_q;
  logic [AW-1:0] waddr_q, raddr_q;
  logic [DW-1:0] data_q, rdata0_q, rdata1_q;
  logic          win_d, we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic [1:0]    gnt_d;
  assign win_d   = (m0_req & m1_req) ? ptr_q : m1_req;
  assign we_d    = win_d ? m1_we : m0_we;
  assign addr_d  = win_d ? m1_addr : m0_addr;
  assign wdata_d = win_d ? m1_wdata : m0_wdata;
  assign gnt_d   = win_d ? 2'b10 : 2'b01;
  // Sequencer: IDLE arbitrates and preloads the ISSUE strobes, so every output is a flop
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      win_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      cnt_q    <= 3'd0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      data_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (m0_req | m1_req) begin
          state_q <= ISSUE;
          win_q   <= win_d;
          ptr_q   <= ~win_d;
          gnt_q   <= gnt_d;
          busy_q  <= 1'b1;
          wr_q    <= we_d;
          rd_q    <= ~we_d;
          waddr_q <= we_d ? addr_d : '0;
          data_q  <= we_d ? wdata_d : '0;
          raddr_q <= we_d ? '0 : addr_d;
        end
        ISSUE: begin
          state_q <= wr_q ? ACK : WAIT;
          ack_q   <= wr_q ? gnt_q : 2'b00;
          cnt_q   <= LAT;
          wr_q    <= 1'b0;
          rd_q    <= 1'b0;
          waddr_q <= '0;
          raddr_q <= '0;
          data_q  <= '0;
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= ACK;
            ack_q   <= gnt_q;
            if (win_q) rdata1_q <= fx_q;
            else rdata0_q <= fx_q;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign fx_wr    = wr_q;
  assign fx_rd    = rd_q;
  assign fx_waddr = waddr_q;
  assign fx_raddr = raddr_q;
  assign fx_data  = data_q;
  assign gnt      = gnt_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_fx_arb.sv
// tb_fx_arb: randomized bench for fx_arb against a transaction-level arbitration model
module tb_fx_arb;
  localparam int AW = 22, DW = 8, RD_LAT = 2;
  logic          clk_sys = 1'b0, rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, fx_q = '0;
  logic          m0_ack, m1_ack, fx_wr, fx_rd, busy;
  logic [DW-1:0] m0_rdata, m1_rdata, fx_data;
  logic [AW-1:0] fx_waddr, fx_raddr;
  logic [1:0]    gnt;
  int            cyc = 0, n_cmp = 0, n_err = 0, lat, l0, l1;
  logic          t_act = 1'b0, t_m = 1'b0, t_we = 1'b0, m_ptr = 1'b0, armed = 1'b0;
  logic          use_force = 1'b0, on, is, w;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wd = '0, t_rv = '0, force_rv = '0;
  logic [DW-1:0] e_rd [2] = '{'0, '0};
  int            t_issue = 0, t_ack = 0, m_free = 0;
  logic [1:0]    prev_gnt = 2'b00;
  int            gq[$];
  logic          s_req [2] = '{1'b0, 1'b0};
  logic [DW-1:0] s_fxq [2] = '{'0, '0};
  logic          s_ack [2], s_m0ack [2], s_wr [2], s_rd [2], s_busy [2];
  logic [DW-1:0] s_rdata [2], s_m0rd [2], s_data [2];
  logic [AW-1:0] s_waddr [2], s_raddr [2];
  logic [1:0]    s_gnt [2];

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  fx_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
    .clk_sys(clk_sys), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q), .gnt(gnt), .busy(busy)
  );

  for (genvar g = 0; g < 2; g++) begin : g_sw
    fx_arb #(.AW(AW), .DW(DW), .RD_LAT(g == 0 ? 1 : 7)) u_sw (
      .clk_sys(clk_sys), .rst(rst),
      .m0_req(1'b0), .m0_we(1'b0), .m0_addr('0), .m0_wdata('0),
      .m0_ack(s_m0ack[g]), .m0_rdata(s_m0rd[g]),
      .m1_req(s_req[g]), .m1_we(1'b0), .m1_addr(22'h000203), .m1_wdata('0),
      .m1_ack(s_ack[g]), .m1_rdata(s_rdata[g]),
      .fx_wr(s_wr[g]), .fx_waddr(s_waddr[g]), .fx_data(s_data[g]),
      .fx_rd(s_rd[g]), .fx_raddr(s_raddr[g]), .fx_q(s_fxq[g]), .gnt(s_gnt[g]), .busy(s_busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: one transaction at a time; arbitration and timing from plain cycle arithmetic
  always @(negedge clk_sys) begin
    if (t_act && cyc == t_ack && !t_we) e_rd[t_m] = t_rv;
    on = t_act && cyc >= t_issue && cyc <= t_ack;
    is = on && cyc == t_issue;
    if (armed) begin
      check("gnt", 32'(gnt), on ? (t_m ? 32'd2 : 32'd1) : 32'd0);
      check("busy", 32'(busy), 32'(on));
      check("fx_wr", 32'(fx_wr), 32'(is && t_we));
      check("fx_waddr", 32'(fx_waddr), (is && t_we) ? 32'(t_addr) : 32'd0);
      check("fx_data", 32'(fx_data), (is && t_we) ? 32'(t_wd) : 32'd0);
      check("fx_rd", 32'(fx_rd), 32'(is && !t_we));
      check("fx_raddr", 32'(fx_raddr), (is && !t_we) ? 32'(t_addr) : 32'd0);
      check("m0_ack", 32'(m0_ack), 32'(on && cyc == t_ack && !t_m));
      check("m1_ack", 32'(m1_ack), 32'(on && cyc == t_ack && t_m));
      check("m0_rdata", 32'(m0_rdata), 32'(e_rd[0]));
      check("m1_rdata", 32'(m1_rdata), 32'(e_rd[1]));
    end
    if (gnt != 2'b00 && prev_gnt == 2'b00) gq.push_back(int'(gnt[1]));
    prev_gnt = gnt;
    if (rst) begin
      t_act = 1'b0;
      m_ptr = 1'b0;
      e_rd[0] = '0;
      e_rd[1] = '0;
      m_free = cyc + 1;
      armed = 1'b1;
    end else if (cyc >= m_free && (m0_req || m1_req)) begin
      w = (m0_req && m1_req) ? m_ptr : m1_req;
      m_ptr = !w;
      t_act = 1'b1;
      t_m = w;
      t_we = w ? m1_we : m0_we;
      t_addr = w ? m1_addr : m0_addr;
      t_wd = w ? m1_wdata : m0_wdata;
      t_issue = cyc + 1;
      t_ack = cyc + 2 + (t_we ? 0 : RD_LAT);
      m_free = t_ack + 1;
      t_rv = use_force ? force_rv : DW'($urandom);
    end
  end

  // Bus model: correct data only in the sample cycle, guaranteed-different junk otherwise
  always @(posedge clk_sys) begin
    #1;
    fx_q = (t_act && !t_we && cyc == t_issue + RD_LAT) ? t_rv : t_rv ^ DW'($urandom_range(1, 255));
  end

  task automatic txn(input bit m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int l);
    int n0;
    bit seen = 1'b0;
    @(posedge clk_sys); #1;
    if (m) begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    else begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    n0 = cyc;
    l = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk_sys);
      if ((m ? m1_ack : m0_ack) === 1'b1) begin seen = 1'b1; l = cyc - n0; end
    end
    check("txn_ack_seen", 32'(seen), 32'd1);
    if (m) m1_req = 1'b0;
    else m0_req = 1'b0;
  endtask

  task automatic run(input bit m, input int n, input int maxgap);
    int l;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) @(posedge clk_sys);
      txn(m, 1'($urandom), AW'($urandom), DW'($urandom), l);
    end
  endtask

  task automatic sweep(input int g, input int lt);
    logic [DW-1:0] v;
    int at = -1;
    v = DW'($urandom);
    @(posedge clk_sys); #1;
    s_req[g] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk_sys); #1; end
      s_fxq[g] = (k == 1 + lt) ? v : v ^ DW'($urandom_range(1, 255));
      @(negedge clk_sys);
      check("sweep_fx_rd", 32'(s_rd[g]), 32'(k == 1));
      if (s_ack[g] && at < 0) begin at = k; s_req[g] = 1'b0; end
    end
    check("sweep_ack_cycle", at, 2 + lt);
    check("sweep_rdata", 32'(s_rdata[g]), 32'(v));
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;
    txn(0, 1'b1, 22'h000105, 8'hA5, lat);
    check("wr_ack_cycle", lat, 2);
    use_force = 1'b1;
    force_rv = 8'h3C;
    txn(1, 1'b0, 22'h000203, 8'h00, lat);
    use_force = 1'b0;
    check("rd_ack_cycle", lat, 2 + RD_LAT);
    check("rd_m1_rdata", 32'(m1_rdata), 32'h3C);
    fork
      txn(0, 1'b0, AW'($urandom), '0, l0);
      begin
        repeat (2) @(posedge clk_sys);
        txn(1, 1'b1, AW'($urandom), DW'($urandom), l1);
      end
    join
    check("late_m0_ack", l0, 2 + RD_LAT);
    check("late_m1_ack", l1, 3 + RD_LAT);
    @(posedge clk_sys); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = AW'($urandom);
    repeat (2) @(posedge clk_sys);
    #1 rst = 1'b1; m0_req = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;
    txn(0, 1'b1, AW'($urandom), DW'($urandom), lat);
    check("post_rst_wr_ack", lat, 2);
    @(posedge clk_sys);
    #1 rst = 1'b1;
    @(posedge clk_sys);
    #1 rst = 1'b0;
    gq.delete();
    fork
      run(0, 10, 0);
      run(1, 10, 0);
    join
    check("cont_grants", gq.size(), 20);
    foreach (gq[i]) check("cont_order", gq[i], i % 2);
    fork
      run(0, 15, 3);
      run(1, 15, 3);
    join
    sweep(0, 1);
    sweep(1, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end
endmodule
